// File: rtl/lfsr_random_gen.sv
// Parametrised Galois/Fibonacci LFSR stepping once per prescaler tick, with seed load and lock-up recovery.
// Latency: rnd_out and all pulses are registered, so they update on the clock edge that takes the tick or load.
// No backpressure: en gates advancement, and load always acts whatever the state of en.
module lfsr_random_gen #(
    parameter int                 WIDTH        = 5,
    parameter logic [WIDTH-1:0]   TAPS         = 5'b00100,
    parameter bit                 GALOIS       = 1'b1,
    parameter int                 DIV          = 131072,
    parameter logic [WIDTH-1:0]   SEED_DEFAULT = 5'b11111
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] seed_in,
    output logic [WIDTH-1:0] rnd_out,
    output logic             rnd_valid,
    output logic [WIDTH-1:0] step_cnt,
    output logic             period_done,
    output logic             lockup
);

    // A one-bit counter is kept even when DIV=1 so the compare below is always well formed.
    localparam int             PW        = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]  PRESC_MAX = PW'(DIV - 1);

    logic [PW-1:0]    r_presc;
    logic [WIDTH-1:0] r_state;
    logic [WIDTH-1:0] r_seed;
    logic [WIDTH-1:0] r_step_cnt;
    logic             r_valid;
    logic             r_period;
    logic             r_lockup;

    logic             w_tick;
    logic             w_zero_state;
    logic [WIDTH-1:0] w_step;
    logic [WIDTH-1:0] w_next;
    logic [WIDTH-1:0] w_seed_eff;

    assign w_tick       = en && (r_presc == PRESC_MAX);
    assign w_zero_state = (r_state == '0);
    // An all-zero state would stick forever, so it is replaced by the default seed instead of stepping.
    assign w_next       = w_zero_state ? SEED_DEFAULT : w_step;
    // A zero seed is rejected up front for the same reason.
    assign w_seed_eff   = (seed_in == '0) ? SEED_DEFAULT : seed_in;

    // One LFSR step from the current state in the selected form.
    always_comb begin
        w_step = '0;
        if (GALOIS) begin
            w_step[0] = r_state[WIDTH-1];
            for (int i = 1; i < WIDTH; i++) begin
                w_step[i] = r_state[i-1] ^ (TAPS[i] & r_state[WIDTH-1]);
            end
        end else begin
            w_step = {r_state[WIDTH-2:0], ^(r_state & TAPS)};
        end
    end

    // Clock-enable prescaler: counts only while enabled and restarts on every load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
        end else if (load) begin
            r_presc <= '0;
        end else if (en) begin
            r_presc <= w_tick ? '0 : r_presc + 1'b1;
        end
    end

    // LFSR state, active seed and step counter; load takes priority over a coincident tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= SEED_DEFAULT;
            r_seed     <= SEED_DEFAULT;
            r_step_cnt <= '0;
        end else if (load) begin
            r_state    <= w_seed_eff;
            r_seed     <= w_seed_eff;
            r_step_cnt <= '0;
        end else if (w_tick) begin
            r_state    <= w_next;
            r_step_cnt <= r_step_cnt + 1'b1;
        end
    end

    // Single-cycle status pulses, recomputed every cycle so en can never stretch them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid  <= 1'b0;
            r_period <= 1'b0;
            r_lockup <= 1'b0;
        end else begin
            r_valid  <= !load && w_tick;
            r_period <= !load && w_tick && (w_next == r_seed);
            r_lockup <= load ? (seed_in == '0) : (w_tick && w_zero_state);
        end
    end

    assign rnd_out     = r_state;
    assign rnd_valid   = r_valid;
    assign step_cnt    = r_step_cnt;
    assign period_done = r_period;
    assign lockup      = r_lockup;

endmodule

// File: tb/tb_lfsr_random_gen.sv
// Bench for lfsr_random_gen: three instances (Galois DIV=1, Galois DIV=4, Fibonacci DIV=1).
// Expected states are queued as stimulus is driven and popped when rnd_valid is seen.
// Inputs change 1 time unit after the rising edge; outputs are sampled at that same point.
module tb_lfsr_random_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       en0, load0, en1, load1, en2, load2;
    logic [4:0] seed0, seed1, seed2;
    logic [4:0] rnd0, cnt0, rnd1, cnt1, rnd2, cnt2;
    logic       v0, p0, l0, v1, p1, l1, v2, p2, l2;

    lfsr_random_gen #(.WIDTH(5), .TAPS(5'b00100), .GALOIS(1'b1), .DIV(1), .SEED_DEFAULT(5'b11111)) u0 (
        .clk(clk), .rst_n(rst_n), .en(en0), .load(load0), .seed_in(seed0),
        .rnd_out(rnd0), .rnd_valid(v0), .step_cnt(cnt0), .period_done(p0), .lockup(l0));

    lfsr_random_gen #(.WIDTH(5), .TAPS(5'b00100), .GALOIS(1'b1), .DIV(4), .SEED_DEFAULT(5'b11111)) u1 (
        .clk(clk), .rst_n(rst_n), .en(en1), .load(load1), .seed_in(seed1),
        .rnd_out(rnd1), .rnd_valid(v1), .step_cnt(cnt1), .period_done(p1), .lockup(l1));

    lfsr_random_gen #(.WIDTH(5), .TAPS(5'b10100), .GALOIS(1'b0), .DIV(1), .SEED_DEFAULT(5'b11111)) u2 (
        .clk(clk), .rst_n(rst_n), .en(en2), .load(load2), .seed_in(seed2),
        .rnd_out(rnd2), .rnd_valid(v2), .step_cnt(cnt2), .period_done(p2), .lockup(l2));

    int         n_chk  = 0;
    int         n_fail = 0;
    logic [4:0] q0[$];
    logic [4:0] q2[$];
    logic [4:0] m0, m2;
    logic [4:0] first_exp [3];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [4:0] lfsr_next(input logic [4:0] s, input bit gal, input logic [4:0] taps);
        logic [4:0] n;
        if (gal) begin
            n[0] = s[4];
            for (int i = 1; i < 5; i++) n[i] = s[i-1] ^ (taps[i] & s[4]);
        end else begin
            n = {s[3:0], ^(s & taps)};
        end
        return n;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Pop the scoreboard for u0 whenever a step is reported.
    task automatic score0(input string tag);
        check({tag, "_valid"}, 32'(v0), 32'd1);
        if (v0 && q0.size() > 0) check({tag, "_rnd"}, 32'(rnd0), 32'(q0.pop_front()));
    endtask

    task automatic score2(input string tag);
        check({tag, "_valid"}, 32'(v2), 32'd1);
        if (v2 && q2.size() > 0) check({tag, "_rnd"}, 32'(rnd2), 32'(q2.pop_front()));
    endtask

    initial begin
        first_exp[0] = 5'b11011;
        first_exp[1] = 5'b10011;
        first_exp[2] = 5'b00011;
        rst_n = 1'b0;
        en0 = 0; load0 = 0; seed0 = '0;
        en1 = 0; load1 = 0; seed1 = '0;
        en2 = 0; load2 = 0; seed2 = '0;
        repeat (2) cyc();

        // Reset state
        check("rst_rnd0", 32'(rnd0), 32'h1f);
        check("rst_cnt0", 32'(cnt0), 32'd0);
        check("rst_pulses0", 32'({v0, p0, l0}), 32'd0);
        check("rst_rnd1", 32'(rnd1), 32'h1f);
        check("rst_rnd2", 32'(rnd2), 32'h1f);
        rst_n = 1'b1;
        cyc();
        check("idle_rnd0", 32'(rnd0), 32'h1f);

        // Full Galois period from the default seed
        en0 = 1'b1;
        m0  = 5'b11111;
        for (int k = 1; k <= 31; k++) begin
            m0 = lfsr_next(m0, 1'b1, 5'b00100);
            q0.push_back(m0);
            cyc();
            score0("gal");
            if (k <= 3) check("gal_first", 32'(rnd0), 32'(first_exp[k-1]));
            check("gal_cnt", 32'(cnt0), 32'(k));
            check("gal_period", 32'(p0), 32'(k == 31));
        end
        check("gal_wrap_rnd", 32'(rnd0), 32'h1f);

        // Zero seed load with a coincident tick
        load0 = 1'b1; seed0 = 5'b00000;
        cyc();
        check("ld0_rnd", 32'(rnd0), 32'h1f);
        check("ld0_lockup", 32'(l0), 32'd1);
        check("ld0_cnt", 32'(cnt0), 32'd0);
        check("ld0_valid", 32'(v0), 32'd0);
        load0 = 1'b0; en0 = 1'b0;
        cyc();
        check("ld0_lockup_once", 32'(l0), 32'd0);
        check("frz_valid", 32'(v0), 32'd0);
        cyc();
        check("frz_rnd", 32'(rnd0), 32'h1f);
        check("frz_cnt", 32'(cnt0), 32'd0);

        // Load beats tick; stepping then resumes from the new seed
        load0 = 1'b1; seed0 = 5'b01010; en0 = 1'b1;
        cyc();
        check("ldt_rnd", 32'(rnd0), 32'h0a);
        check("ldt_valid", 32'(v0), 32'd0);
        check("ldt_lockup", 32'(l0), 32'd0);
        load0 = 1'b0;
        m0 = lfsr_next(5'b01010, 1'b1, 5'b00100);
        q0.push_back(m0);
        cyc();
        score0("ldt_step");
        check("ldt_step_cnt", 32'(cnt0), 32'd1);
        en0 = 1'b0;

        // DIV=4 prescaler with en dropped mid-count
        en1 = 1'b1;
        repeat (2) begin
            cyc();
            check("div_pre_valid", 32'(v1), 32'd0);
        end
        en1 = 1'b0;
        repeat (3) begin
            cyc();
            check("div_frz_valid", 32'(v1), 32'd0);
            check("div_frz_rnd", 32'(rnd1), 32'h1f);
        end
        en1 = 1'b1;
        cyc();
        check("div_3rd_valid", 32'(v1), 32'd0);
        cyc();
        check("div_step_valid", 32'(v1), 32'd1);
        check("div_step_rnd", 32'(rnd1), 32'h1b);
        check("div_step_cnt", 32'(cnt1), 32'd1);
        cyc();
        check("div_pulse_once", 32'(v1), 32'd0);
        repeat (2) cyc();
        // Prescaler now sits at DIV-1: load and tick coincide
        load1 = 1'b1; seed1 = 5'b01010;
        cyc();
        check("div_ld_rnd", 32'(rnd1), 32'h0a);
        check("div_ld_valid", 32'(v1), 32'd0);
        load1 = 1'b0;
        repeat (3) begin
            cyc();
            check("div_restart_valid", 32'(v1), 32'd0);
            check("div_restart_rnd", 32'(rnd1), 32'h0a);
        end
        cyc();
        check("div_restart_step", 32'(v1), 32'd1);
        check("div_restart_rnd2", 32'(rnd1), 32'h14);
        en1 = 1'b0;

        // Fibonacci, taps 10100, seed 00001: maximal period
        load2 = 1'b1; seed2 = 5'b00001;
        cyc();
        check("fib_ld_rnd", 32'(rnd2), 32'h01);
        load2 = 1'b0; en2 = 1'b1;
        m2 = 5'b00001;
        for (int k = 1; k <= 31; k++) begin
            m2 = lfsr_next(m2, 1'b0, 5'b10100);
            q2.push_back(m2);
            cyc();
            score2("fib");
            check("fib_period", 32'(p2), 32'(k == 31));
        end
        check("fib_wrap_rnd", 32'(rnd2), 32'h01);
        check("fib_cnt", 32'(cnt2), 32'd31);
        for (int k = 0; k < 3; k++) begin
            m2 = lfsr_next(m2, 1'b0, 5'b10100);
            q2.push_back(m2);
            cyc();
            score2("fib_more");
        end

        // Reset mid-run, away from any edge
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_rnd2", 32'(rnd2), 32'h1f);
        check("arst_pulses2", 32'({v2, p2, l2}), 32'd0);
        check("arst_cnt2", 32'(cnt2), 32'd0);
        check("arst_rnd0", 32'(rnd0), 32'h1f);
        check("arst_pulses0", 32'({v0, p0, l0}), 32'd0);
        cyc();
        check("arst_hold_valid2", 32'(v2), 32'd0);
        check("arst_hold_rnd2", 32'(rnd2), 32'h1f);
        en2 = 1'b0;
        rst_n = 1'b1;
        cyc();
        check("q0_drained", 32'(q0.size()), 32'd0);
        check("q2_drained", 32'(q2.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
